// File: rtl/img_window_feeder_pkg.sv
// -----------------------------------------------------------------------------
// img_window_feeder_pkg
// Shared definitions for the 2x2 window feeder:
//   - FSM state encoding (IDLE / FILL / STREAM / DONE)
//   - window-count helper and the window count of the default 16x16 image
// No ports; imported by img_window_feeder and by its bench.
// -----------------------------------------------------------------------------
package img_window_feeder_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int DEFAULT_IMG_SIZE = 16;

  // Stride-1 2x2 windows over an N x N image: (N-1)^2 of them.
  function automatic int win_count(input int img_size);
    return (img_size - 1) * (img_size - 1);
  endfunction

  localparam int WIN_COUNT = win_count(DEFAULT_IMG_SIZE);

endpackage

// File: rtl/img_window_feeder_pixel_buf.sv
// -----------------------------------------------------------------------------
// img_pixel_buf
// Pixel storage for one IMG_SIZE x IMG_SIZE image, PIX_W bits per pixel.
// Not reset: unwritten locations keep whatever they held before.
// Ports:
//   clk      - write clock
//   wr_en    - write one memory word (WORD_PIX pixels) this cycle
//   wr_addr  - word index; pixel p lands at linear address wr_addr*WORD_PIX+p
//   wr_data  - packed pixels, pixel 0 in the low PIX_W bits
//   rd_addr  - four independent linear pixel addresses
//   rd_data  - the four pixels, combinational read
// -----------------------------------------------------------------------------
module img_pixel_buf #(
  parameter int IMG_SIZE = 16,
  parameter int PIX_W    = 8,
  parameter int WORD_PIX = 4,
  localparam int DEPTH   = IMG_SIZE * IMG_SIZE,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int WORDS   = DEPTH / WORD_PIX,
  localparam int WADDR_W = $clog2(WORDS)
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [WADDR_W-1:0]            wr_addr,
  input  logic [WORD_PIX*PIX_W-1:0]     wr_data,
  input  logic [3:0][ADDR_W-1:0]        rd_addr,
  output logic [3:0][PIX_W-1:0]         rd_data
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int p = 0; p < WORD_PIX; p++) begin
        mem[ADDR_W'(int'(wr_addr) * WORD_PIX + p)] <= wr_data[p*PIX_W +: PIX_W];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_data[i] = mem[rd_addr[i]];
    end
  end

endmodule

// File: rtl/img_window_feeder.sv
// -----------------------------------------------------------------------------
// img_window_feeder
// Buffers one image written word-by-word by a memory reader, then streams
// every stride-1 2x2 window in raster order (column fastest).
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   img_wr_en/idx/data- image word writes (accepted only in IDLE and FILL)
//   load_done         - one-cycle pulse: image load complete, start streaming
//   win_valid/ready   - window handshake
//   win_data          - {br, bl, tr, tl}, tl in the low PIX_W bits
//   win_row/col       - top-left coordinate of the presented window
//   win_last          - presented window is (IMG_SIZE-2, IMG_SIZE-2)
//   busy              - state is not IDLE
//   done              - high for the single cycle spent in DONE
//   fsm_state         - current FSM state for observation
//
// Handshake: a window transfers on a rising edge where win_valid and
// win_ready are both high. While win_valid is high and win_ready low, all
// window outputs hold. win_valid never drops without a transfer except on
// reset; the next window appears the cycle after a transfer.
// -----------------------------------------------------------------------------
module img_window_feeder
  import img_window_feeder_pkg::*;
#(
  parameter int IMG_SIZE = 16,
  parameter int PIX_W    = 8,
  parameter int WORD_PIX = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      img_wr_en,
  input  logic [7:0]                img_wr_idx,
  input  logic [WORD_PIX*PIX_W-1:0] img_wr_data,
  input  logic                      load_done,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [4*PIX_W-1:0]        win_data,
  output logic [7:0]                win_row,
  output logic [7:0]                win_col,
  output logic                      win_last,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                fsm_state
);

  localparam int DEPTH   = IMG_SIZE * IMG_SIZE;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int WORDS   = DEPTH / WORD_PIX;
  localparam int WADDR_W = $clog2(WORDS);
  localparam logic [7:0] LAST_IDX = 8'(IMG_SIZE - 2);

  logic [1:0]              state;
  logic                    buf_wr_en;
  logic [3:0][ADDR_W-1:0]  rd_addr;
  logic [3:0][PIX_W-1:0]   rd_data;
  logic [7:0]              fetch_row;
  logic [7:0]              fetch_col;
  logic [ADDR_W-1:0]       base_addr;
  logic                    load_win;
  logic                    accept_last;

  // Out-of-range word indices are dropped here, so they never reach storage.
  assign buf_wr_en = img_wr_en
                   && (state == ST_IDLE || state == ST_FILL)
                   && (int'(img_wr_idx) < WORDS);

  img_pixel_buf #(
    .IMG_SIZE (IMG_SIZE),
    .PIX_W    (PIX_W),
    .WORD_PIX (WORD_PIX)
  ) u_pixel_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_addr (WADDR_W'(img_wr_idx)),
    .wr_data (img_wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Coordinate of the window to load on the next edge: (0,0) when nothing
  // is presented yet, otherwise the raster successor of the presented one.
  always_comb begin
    fetch_row = 8'd0;
    fetch_col = 8'd0;
    if (win_valid) begin
      if (win_col == LAST_IDX) begin
        fetch_row = win_row + 8'd1;
        fetch_col = 8'd0;
      end else begin
        fetch_row = win_row;
        fetch_col = win_col + 8'd1;
      end
    end
  end

  assign base_addr  = ADDR_W'(int'(fetch_row) * IMG_SIZE + int'(fetch_col));
  assign rd_addr[0] = base_addr;                                  // tl
  assign rd_addr[1] = base_addr + ADDR_W'(1);                     // tr
  assign rd_addr[2] = base_addr + ADDR_W'(IMG_SIZE);              // bl
  assign rd_addr[3] = base_addr + ADDR_W'(IMG_SIZE + 1);          // br

  // Within STREAM, win_valid is low only on the entry cycle, so that is
  // where the first window gets loaded.
  assign load_win    = (state == ST_STREAM) && (!win_valid || (win_ready && !win_last));
  assign accept_last = (state == ST_STREAM) && win_valid && win_ready && win_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      win_valid <= 1'b0;
      win_data  <= '0;
      win_row   <= 8'd0;
      win_col   <= 8'd0;
      win_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_done)      state <= ST_STREAM;
          else if (img_wr_en) state <= ST_FILL;
        end
        ST_FILL: begin
          if (load_done) state <= ST_STREAM;
        end
        ST_STREAM: begin
          if (accept_last) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (load_win) begin
        win_valid <= 1'b1;
        win_data  <= rd_data;
        win_row   <= fetch_row;
        win_col   <= fetch_col;
        win_last  <= (fetch_row == LAST_IDX) && (fetch_col == LAST_IDX);
      end else if (accept_last) begin
        win_valid <= 1'b0;
        win_last  <= 1'b0;
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_img_window_feeder.sv
// -----------------------------------------------------------------------------
// tb_img_window_feeder
// Directed bench for img_window_feeder (16x16 image, 8-bit pixels, 4 per word).
// A pixel model of the image builds the expected window queue; fixed windows
// are also checked against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_img_window_feeder;
  import img_window_feeder_pkg::*;

  localparam int IMG_SIZE = 16;
  localparam int PIX_W    = 8;
  localparam int WORD_PIX = 4;
  localparam int NPIX     = IMG_SIZE * IMG_SIZE;
  localparam int NWORDS   = NPIX / WORD_PIX;

  // ---------------- clock / reset ----------------
  logic                      clk;
  logic                      rst_n;
  logic                      img_wr_en;
  logic [7:0]                img_wr_idx;
  logic [WORD_PIX*PIX_W-1:0] img_wr_data;
  logic                      load_done;
  logic                      win_valid;
  logic                      win_ready;
  logic [4*PIX_W-1:0]        win_data;
  logic [7:0]                win_row;
  logic [7:0]                win_col;
  logic                      win_last;
  logic                      busy;
  logic                      done;
  logic [1:0]                fsm_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  img_window_feeder #(
    .IMG_SIZE (IMG_SIZE),
    .PIX_W    (PIX_W),
    .WORD_PIX (WORD_PIX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .img_wr_en   (img_wr_en),
    .img_wr_idx  (img_wr_idx),
    .img_wr_data (img_wr_data),
    .load_done   (load_done),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .win_data    (win_data),
    .win_row     (win_row),
    .win_col     (win_col),
    .win_last    (win_last),
    .busy        (busy),
    .done        (done),
    .fsm_state   (fsm_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [PIX_W-1:0]   pix_model [NPIX];
  logic [4*PIX_W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4*PIX_W-1:0] model_win(input int r, input int c);
    return {pix_model[(r+1)*IMG_SIZE + c + 1], pix_model[(r+1)*IMG_SIZE + c],
            pix_model[r*IMG_SIZE + c + 1],     pix_model[r*IMG_SIZE + c]};
  endfunction

  task automatic check_window(input string tag, input logic [31:0] exp, input int r, input int c);
    check($sformatf("%s_valid(%0d,%0d)", tag, r, c), 64'(win_valid), 64'(1));
    check($sformatf("%s_data(%0d,%0d)", tag, r, c), 64'(win_data), 64'(exp));
    check($sformatf("%s_row(%0d,%0d)", tag, r, c), 64'(win_row), 64'(r));
    check($sformatf("%s_col(%0d,%0d)", tag, r, c), 64'(win_col), 64'(c));
    check($sformatf("%s_last(%0d,%0d)", tag, r, c), 64'(win_last),
          64'((r == IMG_SIZE-2) && (c == IMG_SIZE-2)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_word(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    img_wr_en = 1'b1; img_wr_idx = idx; img_wr_data = data;
    @(negedge clk);
    img_wr_en = 1'b0;
  endtask

  // pattern 0: pixel = addr mod 256; pattern 1: pixel = 255 - addr.
  // done_mode 0: separate load_done pulse; 1: with the last write; 2: none.
  // Returns at a negedge with load_done possibly still high.
  task automatic load_image(input int pattern, input int done_mode);
    for (int w = 0; w < NWORDS; w++) begin
      logic [31:0] d;
      for (int p = 0; p < WORD_PIX; p++) begin
        logic [7:0] pv;
        pv = (pattern == 0) ? 8'(w*WORD_PIX + p) : 8'(255 - (w*WORD_PIX + p));
        d[p*PIX_W +: PIX_W] = pv;
        pix_model[w*WORD_PIX + p] = pv;
      end
      @(negedge clk);
      if (w == 1) check("busy_in_fill", {62'd0, busy, 1'b0} | 64'(fsm_state) << 2,
                        {62'd0, 1'b1, 1'b0} | 64'(ST_FILL) << 2);
      img_wr_en = 1'b1; img_wr_idx = 8'(w); img_wr_data = d;
      if (w == NWORDS-1 && done_mode == 1) load_done = 1'b1;
    end
    @(negedge clk);
    img_wr_en = 1'b0;
    load_done = (done_mode == 0);
  endtask

  task automatic stream_check(input bit toggle, input bit wr_stream, input int abort_at,
                              output logic [31:0] first_data, output logic [31:0] last_data);
    int  r;
    int  c;
    bit  got_valid;
    logic [31:0] exp;
    first_data = '0;
    last_data  = '0;
    exp_q.delete();
    for (int rr = 0; rr < IMG_SIZE-1; rr++)
      for (int cc = 0; cc < IMG_SIZE-1; cc++)
        exp_q.push_back(model_win(rr, cc));
    @(negedge clk);
    load_done = 1'b0;
    win_ready = 1'b1;
    if (wr_stream) begin
      img_wr_en = 1'b1; img_wr_idx = 8'd0; img_wr_data = 32'hAAAA_AAAA;
    end
    got_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (win_valid) begin got_valid = 1'b1; break; end
      @(negedge clk);
    end
    check("first_valid_within_budget", 64'(got_valid), 64'(1));
    if (!got_valid) begin img_wr_en = 1'b0; return; end
    r = 0; c = 0;
    for (int n = 0; n < WIN_COUNT; n++) begin
      exp = exp_q.pop_front();
      if (n == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_valid", 64'(win_valid), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done", 64'(done), 64'(0));
        end
        exp_q.delete();
        return;
      end
      check_window("win", exp, r, c);
      if (n == 0) first_data = win_data;
      if (n == WIN_COUNT-1) last_data = win_data;
      if (wr_stream && n == 2) img_wr_en = 1'b0;
      if (toggle) begin
        win_ready = 1'b0;
        @(negedge clk);
        check_window("hold", exp, r, c);
      end
      win_ready = 1'b1;
      @(negedge clk);
      if (c == IMG_SIZE-2) begin c = 0; r++; end else c++;
    end
    check("end_valid_low", 64'(win_valid), 64'(0));
    check("end_done_pulse", 64'(done), 64'(1));
    check("end_busy_in_done", 64'(busy), 64'(1));
    @(negedge clk);
    check("idle_done_low", 64'(done), 64'(0));
    check("idle_busy_low", 64'(busy), 64'(0));
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] first_d;
  logic [31:0] last_d;

  initial begin
    rst_n = 1'b0; img_wr_en = 1'b0; img_wr_idx = 8'd0; img_wr_data = '0;
    load_done = 1'b0; win_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(win_valid), 64'(0));
    check("rst_data", 64'(win_data), 64'(0));
    check("rst_row", 64'(win_row), 64'(0));
    check("rst_col", 64'(win_col), 64'(0));
    check("rst_last", 64'(win_last), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_state", 64'(fsm_state), 64'(ST_IDLE));
    rst_n = 1'b1;

    // Full-throughput stream of the address pattern
    load_image(0, 0);
    stream_check(1'b0, 1'b0, -1, first_d, last_d);
    check("t1_first_const", 64'(first_d), 64'(32'h1110_0100));
    check("t1_last_const", 64'(last_d), 64'(32'hFFFE_EFEE));

    // Alternating ready with hold checks
    load_image(0, 0);
    stream_check(1'b1, 1'b0, -1, first_d, last_d);
    check("t2_first_const", 64'(first_d), 64'(32'h1110_0100));
    check("t2_last_const", 64'(last_d), 64'(32'hFFFE_EFEE));

    // Out-of-range word index before and after the load must change nothing
    write_word(8'd64, 32'hFFFF_FFFF);
    load_image(0, 2);
    write_word(8'd64, 32'hFFFF_FFFF);
    @(negedge clk);
    load_done = 1'b1;
    stream_check(1'b0, 1'b0, -1, first_d, last_d);
    check("t3_first_const", 64'(first_d), 64'(32'h1110_0100));
    check("t3_last_const", 64'(last_d), 64'(32'hFFFE_EFEE));

    // Writes during STREAM are ignored
    load_image(0, 0);
    stream_check(1'b0, 1'b1, -1, first_d, last_d);
    check("t4_first_const", 64'(first_d), 64'(32'h1110_0100));

    // Reset at window 100, then a reload with load_done on the last write
    load_image(0, 0);
    stream_check(1'b0, 1'b0, 100, first_d, last_d);
    load_image(1, 1);
    stream_check(1'b0, 1'b0, -1, first_d, last_d);
    check("t6_first_const", 64'(first_d), 64'(32'hEEEF_FEFF));
    check("t6_last_const", 64'(last_d), 64'(32'h0001_1011));

    // load_done with no writes streams the retained image
    @(negedge clk);
    load_done = 1'b1;
    stream_check(1'b0, 1'b0, -1, first_d, last_d);
    check("t7_last_const", 64'(last_d), 64'(32'h0001_1011));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
